// File: rtl/fetch_icb_bridge_pkg.sv
// fetch_icb_bridge_pkg: shared widths and PC alignment helper for the fetch/ICB bridge
package fetch_icb_bridge_pkg;
  localparam int DEF_PC_WIDTH    = 32;
  localparam int DEF_INSTR_WIDTH = 32;
  function automatic logic pc_mis(input logic [1:0] lsb, input logic c_ext);
    return c_ext ? lsb[0] : |lsb;
  endfunction
endpackage

// File: rtl/fetch_ost_fifo.sv
// fetch_ost_fifo: generic synchronous FIFO tracking outstanding fetches
module fetch_ost_fifo
  import fetch_icb_bridge_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] dout
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wp;
  logic [AW-1:0]    r_rp;
  logic [CW-1:0]    r_cnt;
  logic             w_wr;
  logic             w_rd;
  assign full  = r_cnt == CW'(DEPTH);
  assign empty = r_cnt == '0;
  assign w_wr  = push & ~full;
  assign w_rd  = pop & ~empty;
  assign dout  = r_mem[r_rp];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_wr) r_wp <= (r_wp == AW'(DEPTH - 1)) ? '0 : r_wp + 1'b1;
      if (w_rd) r_rp <= (r_rp == AW'(DEPTH - 1)) ? '0 : r_rp + 1'b1;
      r_cnt <= r_cnt + CW'(w_wr) - CW'(w_rd);
    end
  always_ff @(posedge clk)
    if (w_wr) r_mem[r_wp] <= din;
endmodule

// File: rtl/fetch_icb_bridge.sv
// fetch_icb_bridge: forwards IFU fetches to ICB, answers misaligned PCs locally, keeps responses in order
module fetch_icb_bridge
  import fetch_icb_bridge_pkg::*;
#(
  parameter int PC_WIDTH    = DEF_PC_WIDTH,
  parameter int INSTR_WIDTH = DEF_INSTR_WIDTH,
  parameter int OST_DEPTH   = 2,
  parameter int C_EXT       = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   if_req_valid_i,
  output logic                   if_req_ready_o,
  input  logic [PC_WIDTH-1:0]    if_req_pc_i,
  output logic                   if_resp_valid_o,
  input  logic                   if_resp_ready_i,
  output logic                   if_resp_misalign_o,
  output logic                   if_resp_bus_err_o,
  output logic [INSTR_WIDTH-1:0] if_resp_instr_o,
  output logic                   icb_cmd_valid_o,
  input  logic                   icb_cmd_ready_i,
  output logic [PC_WIDTH-1:0]    icb_cmd_addr_o,
  output logic                   icb_cmd_read_o,
  input  logic                   icb_rsp_valid_i,
  output logic                   icb_rsp_ready_o,
  input  logic [INSTR_WIDTH-1:0] icb_rsp_rdata_i,
  input  logic                   icb_rsp_err_i
);
  logic       w_mis;
  logic       w_full;
  logic       w_empty;
  logic [0:0] w_dout;
  logic       w_head_mis;
  logic       w_head_bus;
  assign w_mis      = pc_mis(if_req_pc_i[1:0], C_EXT != 0);
  assign w_head_mis = ~w_empty & w_dout[0];
  assign w_head_bus = ~w_empty & ~w_dout[0];
  assign icb_cmd_valid_o    = if_req_valid_i & ~w_mis & ~w_full;
  assign icb_cmd_addr_o     = if_req_pc_i;
  assign icb_cmd_read_o     = 1'b1;
  assign if_req_ready_o     = ~w_full & (w_mis | icb_cmd_ready_i);
  assign if_resp_valid_o    = w_head_mis | (w_head_bus & icb_rsp_valid_i);
  assign if_resp_misalign_o = w_head_mis;
  assign if_resp_bus_err_o  = w_head_bus & icb_rsp_err_i;
  assign if_resp_instr_o    = w_head_bus ? icb_rsp_rdata_i : '0;
  assign icb_rsp_ready_o    = w_head_bus & if_resp_ready_i;
  fetch_ost_fifo #(.WIDTH(1), .DEPTH(OST_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (if_req_valid_i & if_req_ready_o),
    .din   (w_mis),
    .pop   (if_resp_valid_o & if_resp_ready_i),
    .full  (w_full),
    .empty (w_empty),
    .dout  (w_dout)
  );
`ifndef SYNTHESIS
  a_no_stray_rsp: assert property (@(posedge clk) disable iff (!rst_n) !(icb_rsp_valid_i && w_empty));
`endif
endmodule

// File: tb/tb_fetch_icb_bridge.sv
// tb_fetch_icb_bridge: directed self-checking bench for fetch_icb_bridge
module tb_fetch_icb_bridge;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_pc = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic        resp_mis;
  logic        resp_err;
  logic [31:0] resp_instr;
  logic        cmd_valid;
  logic        cmd_ready = 1'b0;
  logic [31:0] cmd_addr;
  logic        cmd_read;
  logic        rsp_valid = 1'b0;
  logic        rsp_ready;
  logic [31:0] rsp_rdata = '0;
  logic        rsp_err = 1'b0;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  fetch_icb_bridge dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .if_req_valid_i     (req_valid),
    .if_req_ready_o     (req_ready),
    .if_req_pc_i        (req_pc),
    .if_resp_valid_o    (resp_valid),
    .if_resp_ready_i    (resp_ready),
    .if_resp_misalign_o (resp_mis),
    .if_resp_bus_err_o  (resp_err),
    .if_resp_instr_o    (resp_instr),
    .icb_cmd_valid_o    (cmd_valid),
    .icb_cmd_ready_i    (cmd_ready),
    .icb_cmd_addr_o     (cmd_addr),
    .icb_cmd_read_o     (cmd_read),
    .icb_rsp_valid_i    (rsp_valid),
    .icb_rsp_ready_o    (rsp_ready),
    .icb_rsp_rdata_i    (rsp_rdata),
    .icb_rsp_err_i      (rsp_err)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    #1;
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_rsp_ready", rsp_ready, 0);
    chk("rst_cmd_valid", cmd_valid, 0);
    chk("rst_cmd_read", cmd_read, 1);
    chk("rst_cnt", dut.u_fifo.r_cnt, 0);
    #12 rst_n = 1'b1;
    tick();
    req_valid = 1; req_pc = 32'h80; cmd_ready = 1; #1;
    chk("t1_cmd_valid", cmd_valid, 1);
    chk("t1_cmd_addr", cmd_addr, 32'h80);
    chk("t1_req_ready", req_ready, 1);
    tick();
    req_valid = 0; rsp_valid = 1; rsp_rdata = 32'h00A00093; #1;
    chk("t1_resp_valid", resp_valid, 1);
    chk("t1_instr", resp_instr, 32'h00A00093);
    chk("t1_mis", resp_mis, 0);
    chk("t1_err", resp_err, 0);
    chk("t1_rsp_ready", rsp_ready, 1);
    tick();
    rsp_valid = 0; #1;
    chk("t1_cnt", dut.u_fifo.r_cnt, 0);
    chk("t1_idle", resp_valid, 0);
    req_valid = 1; req_pc = 32'h82; cmd_ready = 0; #1;
    chk("t2_cmd_valid", cmd_valid, 0);
    chk("t2_req_ready", req_ready, 1);
    tick();
    req_valid = 0; #1;
    chk("t2_resp_valid", resp_valid, 1);
    chk("t2_mis", resp_mis, 1);
    chk("t2_instr", resp_instr, 0);
    chk("t2_err", resp_err, 0);
    chk("t2_rsp_ready", rsp_ready, 0);
    tick();
    chk("t2_cnt", dut.u_fifo.r_cnt, 0);
    cmd_ready = 1; req_valid = 1; req_pc = 32'h0;
    tick();
    req_pc = 32'h6; #1;
    chk("t3_mis_cmd_valid", cmd_valid, 0);
    chk("t3_head_wait", resp_valid, 0);
    tick();
    req_valid = 0; #1;
    chk("t3_cnt2", dut.u_fifo.r_cnt, 2);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("t3_delay", resp_valid, 0);
    end
    rsp_valid = 1; rsp_rdata = 32'h11111111; #1;
    chk("t3_first_valid", resp_valid, 1);
    chk("t3_first_instr", resp_instr, 32'h11111111);
    chk("t3_first_mis", resp_mis, 0);
    tick();
    rsp_valid = 0; #1;
    chk("t3_second_valid", resp_valid, 1);
    chk("t3_second_mis", resp_mis, 1);
    chk("t3_second_instr", resp_instr, 0);
    tick();
    chk("t3_cnt0", dut.u_fifo.r_cnt, 0);
    req_valid = 1; req_pc = 32'h100;
    tick();
    req_pc = 32'h104;
    tick();
    req_pc = 32'h108; #1;
    chk("t4_full_ready", req_ready, 0);
    chk("t4_full_cmd", cmd_valid, 0);
    tick();
    chk("t4_full_hold", dut.u_fifo.r_cnt, 2);
    rsp_valid = 1; rsp_rdata = 32'h1; #1;
    chk("t4_pop_valid", resp_valid, 1);
    chk("t4_pop_ready", req_ready, 0);
    tick();
    rsp_valid = 0; #1;
    chk("t4_cnt1", dut.u_fifo.r_cnt, 1);
    chk("t4_next_ready", req_ready, 1);
    chk("t4_next_addr", cmd_addr, 32'h108);
    tick();
    req_valid = 0; #1;
    chk("t4_cnt2", dut.u_fifo.r_cnt, 2);
    rsp_valid = 1; rsp_rdata = 32'h2; #1;
    chk("t4_drain1", resp_instr, 32'h2);
    tick();
    rsp_rdata = 32'h3; #1;
    chk("t4_drain2", resp_instr, 32'h3);
    tick();
    rsp_valid = 0; #1;
    chk("t4_cnt0", dut.u_fifo.r_cnt, 0);
    req_valid = 1; req_pc = 32'h200;
    tick();
    req_valid = 0; rsp_valid = 1; rsp_err = 1; rsp_rdata = 32'hDEADBEEF; #1;
    chk("t5_err", resp_err, 1);
    chk("t5_instr", resp_instr, 32'hDEADBEEF);
    chk("t5_mis", resp_mis, 0);
    tick();
    rsp_valid = 0; rsp_err = 0;
    req_valid = 1; req_pc = 32'h300;
    tick();
    req_pc = 32'h304;
    tick();
    req_valid = 0; resp_ready = 0; rsp_valid = 1; rsp_rdata = 32'h5;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t6_bp_rsp_ready", rsp_ready, 0);
      chk("t6_bp_valid", resp_valid, 1);
      tick();
    end
    chk("t6_bp_cnt", dut.u_fifo.r_cnt, 2);
    #2 rst_n = 0; rsp_valid = 0; #1;
    chk("t6_rst_valid", resp_valid, 0);
    chk("t6_rst_cnt", dut.u_fifo.r_cnt, 0);
    chk("t6_rst_rsp_ready", rsp_ready, 0);
    #10 rst_n = 1; resp_ready = 1;
    tick();
    chk("t6_post_cnt", dut.u_fifo.r_cnt, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
